led_pattern_sequencer: RTL and testbench
========================================

LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 26, prescaler counter width.
REQ-002 SHALL have parameter NSLOTS, default 8, number of pattern slots (index width 3).
REQ-003 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cfg_we  input  1  config write strobe, one write per asserted cycle.
REQ-006 SHALL have port cfg_addr  input  4  config address: 0-7 pattern slot, 8 LEN, 9 DIV, 10 CTRL.
REQ-007 SHALL have port cfg_wdata  input  8  config write data.
REQ-008 SHALL have port start  input  1  begin sequence, level-sampled per cycle.
REQ-009 SHALL have port stop  input  1  abort sequence, level-sampled per cycle.
REQ-010 SHALL have port led  output  8  current pattern driven to LEDs.
REQ-011 SHALL have port busy  output  1  high in RUN.
REQ-012 SHALL have port done  output  1  one-cycle pulse at one-shot completion.
REQ-013 SHALL have port step_tick  output  1  one-cycle pulse at each prescaler expiry.
REQ-014 SHALL have port index  output  3  current slot index.

Function
REQ-015 SHALL store LEN = cfg_wdata[2:0], 0 meaning 8 slots; DIV = cfg_wdata[4:0], values above PRESCALE_W-1 clamped to PRESCALE_W-1; LOOP = CTRL bit 0.
REQ-016 SHALL accept pattern-slot writes in any state; a write to the slot being displayed updates led on the next step, not mid-step.
REQ-017 SHALL ignore writes to LEN, DIV, CTRL while busy=1; unmapped addresses 11-15 SHALL be ignored.
REQ-018 SHALL implement FSM states IDLE and RUN only.
REQ-019 IDLE: led=0, index=0, prescaler held at 0, busy=0.
REQ-020 IDLE with start=1 and stop=0: next cycle RUN, busy=1, index=0, led=slot[0], prescaler=0.
REQ-021 RUN: prescaler increments every cycle; step_tick=1 in the cycle where prescaler[DIV:0] is all ones (period 2^(DIV+1) cycles); prescaler wraps modulo 2^PRESCALE_W.
REQ-022 On step_tick with index < LEN-1: next cycle index+1, led=slot[index+1].
REQ-023 On step_tick with index = LEN-1 and LOOP=1: next cycle index=0, led=slot[0], remain RUN.
REQ-024 On step_tick with index = LEN-1 and LOOP=0: done=1 for that same cycle; next cycle IDLE, led=0.
REQ-025 stop=1 in any state: next cycle IDLE, led=0, no done pulse; stop wins over simultaneous start or step_tick.
REQ-026 start while RUN SHALL be ignored (no restart).
REQ-027 LEN=1 SHALL hold slot[0] for one period, then loop on slot[0] or finish.
REQ-028 All outputs SHALL be registered except step_tick and done, which are decoded from registered state in the same cycle.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, led=0, index=0, busy=0, done=0, step_tick=0, prescaler=0, all slots=0, LEN=0, DIV=PRESCALE_W-1, LOOP=1.
REQ-030 Reset mid-RUN SHALL abort with no done pulse; reset SHALL dominate start, stop and cfg_we.

Structure
REQ-031 Shared package SHALL hold the state enum, cfg address constants (slot base 0, LEN 8, DIV 9, CTRL 10) and reset defaults for LEN/DIV/LOOP.
REQ-032 Prescaler counter plus tick decode SHALL be one sub-module, led_prescaler (inputs clk, rst_n, run, div; output tick).
REQ-033 Pattern storage SHALL be flops, NSLOTS x 8 bits, inside the top module.

Verification
REQ-034 Reset, then no stimulus 100 cycles -> led=0, busy=0, step_tick never 1.
REQ-035 Write slots 0-3 = 01,02,04,08, LEN=4, DIV=1, LOOP=0, start 1 cycle -> led 01,02,04,08 each 4 cycles, done pulse once with index=3, then led=0, busy=0.
REQ-036 Same config, LOOP=1 -> led sequence 01,02,04,08,01 repeats, step_tick every 4 cycles, no done.
REQ-037 Running with LOOP=1, assert start and stop in the same cycle -> IDLE next cycle, led=0, done stays 0.
REQ-038 While busy, write DIV=0 and LEN=2 -> period stays 4 cycles, length stays 4; after stop, rewrite takes effect on next start.
REQ-039 Pull rst_n low for 1 cycle at index=2 mid-RUN -> next cycle led=0, index=0, DIV reads back as PRESCALE_W-1 behaviour (2^26-cycle period after start).

Source files
------------

// File: rtl/led_pattern_sequencer_pkg.sv
// Shared types and constants for the LED pattern sequencer: FSM states,
// config register map and reset values of the LEN/DIV/LOOP registers.
package led_pattern_sequencer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [3:0] CFG_SLOT_BASE = 4'd0;
    localparam logic [3:0] CFG_LEN       = 4'd8;
    localparam logic [3:0] CFG_DIV       = 4'd9;
    localparam logic [3:0] CFG_CTRL      = 4'd10;

    localparam logic [2:0] LEN_RST  = 3'd0;
    localparam logic       LOOP_RST = 1'b1;

    function automatic logic [4:0] div_rst(input int prescale_w);
        return 5'(prescale_w - 1);
    endfunction

    // The tick decode looks at cnt[div:0], so div must stay inside the counter.
    function automatic logic [4:0] div_clamp(input logic [4:0] v, input int prescale_w);
        if (int'(v) > prescale_w - 1) begin
            return 5'(prescale_w - 1);
        end
        return v;
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Free-running step prescaler: counts while run is high, tick when cnt[div:0] is all ones.
// Counter reads 0 in the first run cycle and is held at 0 whenever run is low; no backpressure.
module led_prescaler #(
    parameter int PRESCALE_W = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [4:0] div,
    output logic       tick
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d, mask;
    logic                  run_q, run_d;

    // run is the sequencer's next state, so run_q mirrors the current state and
    // the count restarts from 0 on the cycle the sequencer enters RUN.
    always_comb begin
        mask = '0;
        for (int i = 0; i < PRESCALE_W; i++) begin
            mask[i] = (i <= int'(div));
        end
        run_d = run;
        cnt_d = '0;
        if (run && run_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign tick = run_q && ((cnt_q & mask) == mask);

endmodule

// File: rtl/led_pattern_sequencer.sv
// Steps the LEDs through up to NSLOTS stored patterns, one per prescaler period, once or looping.
// led/index/busy are registered; done and step_tick are same-cycle decodes; no backpressure.
module led_pattern_sequencer
    import led_pattern_sequencer_pkg::*;
#(
    parameter int PRESCALE_W = 26,
    parameter int NSLOTS     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_we,
    input  logic [3:0] cfg_addr,
    input  logic [7:0] cfg_wdata,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] led,
    output logic       busy,
    output logic       done,
    output logic       step_tick,
    output logic [2:0] index
);

    localparam logic [4:0] DIV_RST = div_rst(PRESCALE_W);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d, last_idx;
    logic [7:0] led_q, led_d;
    logic [7:0] slot_q [NSLOTS];
    logic [7:0] slot_d [NSLOTS];
    logic [2:0] len_q, len_d;
    logic [4:0] div_q, div_d;
    logic       loop_q, loop_d;
    logic [3:0] slot_off;
    logic       tick, run_nxt, done_int;

    assign run_nxt = (state_d == ST_RUN);

    led_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run_nxt),
        .div   (div_q),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        led_d    = led_q;
        slot_d   = slot_q;
        len_d    = len_q;
        div_d    = div_q;
        loop_d   = loop_q;
        done_int = 1'b0;
        // LEN=0 wraps to a last index of 7, i.e. all eight slots.
        last_idx = len_q - 3'd1;
        slot_off = cfg_addr - CFG_SLOT_BASE;

        if (cfg_we) begin
            if (slot_off < 4'(NSLOTS)) begin
                slot_d[slot_off[2:0]] = cfg_wdata;
            end else if (state_q == ST_IDLE) begin
                case (cfg_addr)
                    CFG_LEN:  len_d  = cfg_wdata[2:0];
                    CFG_DIV:  div_d  = div_clamp(cfg_wdata[4:0], PRESCALE_W);
                    CFG_CTRL: loop_d = cfg_wdata[0];
                    default:  ;
                endcase
            end
        end

        if (stop) begin
            state_d = ST_IDLE;
            idx_d   = 3'd0;
            led_d   = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    idx_d = 3'd0;
                    led_d = 8'd0;
                    if (start) begin
                        state_d = ST_RUN;
                        led_d   = slot_q[0];
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        if (idx_q != last_idx) begin
                            idx_d = idx_q + 3'd1;
                            led_d = slot_q[idx_q + 3'd1];
                        end else if (loop_q) begin
                            idx_d = 3'd0;
                            led_d = slot_q[0];
                        end else begin
                            done_int = 1'b1;
                            state_d  = ST_IDLE;
                            idx_d    = 3'd0;
                            led_d    = 8'd0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            led_q   <= 8'd0;
            for (int i = 0; i < NSLOTS; i++) begin
                slot_q[i] <= 8'd0;
            end
            len_q   <= LEN_RST;
            div_q   <= DIV_RST;
            loop_q  <= LOOP_RST;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            led_q   <= led_d;
            slot_q  <= slot_d;
            len_q   <= len_d;
            div_q   <= div_d;
            loop_q  <= loop_d;
        end
    end

    // Gating with rst_n keeps a reset cycle from ever showing a done or tick pulse.
    assign led       = led_q;
    assign index     = idx_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = done_int & rst_n;
    assign step_tick = tick & rst_n;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer; outputs sampled and inputs driven on the falling edge.
module tb_led_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, cfg_we, start, stop;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] led;
    logic       busy, done, step_tick;
    logic [2:0] index;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mslot [8];

    always #5 clk = ~clk;

    led_pattern_sequencer #(.PRESCALE_W(26), .NSLOTS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .start     (start),
        .stop      (stop),
        .led       (led),
        .busy      (busy),
        .done      (done),
        .step_tick (step_tick),
        .index     (index)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [7:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic start_seq();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_led"},   led,   0);
        chk({tag, "_busy"},  busy,  0);
        chk({tag, "_index"}, index, 0);
        chk({tag, "_done"},  done,  0);
    endtask

    // Checks n samples of a run started with start_seq; slots are not written meanwhile.
    task automatic run_chk(input int n, input int per, input int len, input bit loop);
        int idx_e;
        for (int s = 0; s < n; s++) begin
            idx_e = (s / per) % len;
            chk("run_led",   led,       mslot[idx_e]);
            chk("run_index", index,     idx_e);
            chk("run_tick",  step_tick, (s % per) == per - 1);
            chk("run_done",  done,      !loop && (s == per * len - 1));
            chk("run_busy",  busy,      1);
            step();
        end
    endtask

    initial begin
        int         ticks, bad_led, bad_busy, dones;
        logic [7:0] cur_led;
        int         idx_e;

        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 8; i++) mslot[i] = 8'h00;
        step();
        step();
        chk_idle("rst");
        chk("rst_tick", step_tick, 0);
        rst_n = 1'b1;

        // Quiet idle
        ticks = 0; bad_led = 0; bad_busy = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (step_tick) ticks++;
            if (led != 0) bad_led++;
            if (busy) bad_busy++;
        end
        chk("idle_ticks", ticks, 0);
        chk("idle_led", bad_led, 0);
        chk("idle_busy", bad_busy, 0);

        // One-shot: 4 slots, period 4
        mslot[0] = 8'h01; mslot[1] = 8'h02; mslot[2] = 8'h04; mslot[3] = 8'h08;
        for (int i = 0; i < 4; i++) cfg_write(4'(i), mslot[i]);
        cfg_write(4'd8, 8'd4);
        cfg_write(4'd9, 8'd1);
        cfg_write(4'd10, 8'd0);
        start_seq();
        run_chk(16, 4, 4, 1'b0);
        chk_idle("oneshot_end");

        // Looping, then start+stop together
        cfg_write(4'd10, 8'd1);
        start_seq();
        run_chk(20, 4, 4, 1'b1);
        start = 1'b1; stop = 1'b1;
        #1 chk("stopstart_done", done, 0);
        step();
        start = 1'b0; stop = 1'b0;
        chk_idle("stopstart");
        step();
        chk_idle("stopstart_hold");

        // Config writes while busy are ignored; slot write shows at the next visit
        start_seq();
        cur_led = 8'h00;
        for (int s = 0; s < 24; s++) begin
            idx_e = (s / 4) % 4;
            if (s % 4 == 0) cur_led = mslot[idx_e];
            chk("busycfg_led",   led,       cur_led);
            chk("busycfg_index", index,     idx_e);
            chk("busycfg_tick",  step_tick, (s % 4) == 3);
            chk("busycfg_done",  done,      0);
            cfg_we = 1'b0;
            if (s == 1) begin cfg_we = 1'b1; cfg_addr = 4'd9; cfg_wdata = 8'd0; end
            if (s == 2) begin cfg_we = 1'b1; cfg_addr = 4'd8; cfg_wdata = 8'd2; end
            if (s == 5) begin cfg_we = 1'b1; cfg_addr = 4'd1; cfg_wdata = 8'h20; mslot[1] = 8'h20; end
            step();
        end
        cfg_we = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_idle("busycfg_stop");
        cfg_write(4'd9, 8'd0);
        cfg_write(4'd8, 8'd2);
        start_seq();
        run_chk(8, 2, 2, 1'b1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_idle("newcfg_stop");

        // LEN=1 one-shot, then stop on the final tick suppresses done
        cfg_write(4'd8, 8'd1);
        cfg_write(4'd10, 8'd0);
        start_seq();
        run_chk(2, 2, 1, 1'b0);
        chk_idle("len1_end");
        start_seq();
        step();
        stop = 1'b1;
        #1 chk("stoptick_tick", step_tick, 1);
        chk("stoptick_done", done, 0);
        step();
        stop = 1'b0;
        chk_idle("stoptick");

        // Reset mid-run at index 2
        cfg_write(4'd8, 8'd4);
        cfg_write(4'd9, 8'd1);
        cfg_write(4'd10, 8'd1);
        start_seq();
        run_chk(9, 4, 4, 1'b1);
        chk("prerst_index", index, 2);
        rst_n = 1'b0;
        #1 chk("inrst_done", done, 0);
        step();
        rst_n = 1'b1;
        chk_idle("midrst");
        chk("midrst_tick", step_tick, 0);

        // Default DIV gives a 2^26 period: no step within 200 cycles
        cfg_write(4'd0, 8'h5A);
        start_seq();
        ticks = 0; bad_led = 0; bad_busy = 0; dones = 0;
        for (int i = 0; i < 200; i++) begin
            if (step_tick) ticks++;
            if (led != 8'h5A) bad_led++;
            if (!busy) bad_busy++;
            if (done) dones++;
            step();
        end
        chk("defdiv_ticks", ticks, 0);
        chk("defdiv_led", bad_led, 0);
        chk("defdiv_busy", bad_busy, 0);
        chk("defdiv_done", dones, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
